// File: rtl/fetch_mem_unit.sv
// Instruction/data fetch and memory-port unit for a multicycle datapath.
// Owns PC, IR and MDR and runs one request/ack memory transaction at a time, with a timeout.
module fetch_mem_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic        IorD,
   input  logic        PCWrite,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ALUOut,
   input  logic [31:0] RegB,
   output logic [5:0]  OpCode,
   output logic [31:0] Instr,
   output logic [31:0] MDR,
   output logic [31:0] PC,
   output logic        Busy,
   output logic        Err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        irw_q, irw_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        err_q, err_d;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      irw_d   = irw_q;
      mdr_d   = mdr_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      err_d   = err_q;

      case (state_q)
         StIdle: begin
            // Request address is taken from pc_q, so a same-cycle PC update cannot leak in.
            if (PCWrite) begin
               case (PCSrc)
                  2'b00:   pc_d = ALUResult;
                  2'b01:   pc_d = ALUOut;
                  2'b10:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
                  default: pc_d = pc_q;
               endcase
            end
            if (MemRead && MemWrite) begin
               err_d = 1'b1;
            end else if (MemRead) begin
               addr_d  = IorD ? ALUOut : pc_q;
               irw_d   = IRWrite;
               wait_d  = 4'd0;
               state_d = StRead;
            end else if (MemWrite) begin
               addr_d  = ALUOut;
               wdata_d = RegB;
               wait_d  = 4'd0;
               state_d = StWrite;
            end
         end
         StRead, StWrite: begin
            if (mem_ack) begin
               if (state_q == StRead) begin
                  mdr_d = mem_rdata;
                  if (irw_q) instr_d = mem_rdata;
               end
               state_d = StIdle;
            end else begin
               wait_d = wait_q + 4'd1;
               // Counter reaches TIMEOUT on this edge: abandon the transaction.
               if (wait_q == WaitLast) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         wait_q  <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         irw_q   <= 1'b0;
         mdr_q   <= 32'd0;
         instr_q <= 32'd0;
         pc_q    <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         irw_q   <= irw_d;
         mdr_q   <= mdr_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

   assign mem_req   = (state_q != StIdle);
   assign mem_we    = (state_q == StWrite);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign Busy      = (state_q != StIdle);
   assign Err       = err_q;
   assign PC        = pc_q;
   assign MDR       = mdr_q;
   assign Instr     = instr_q;
   assign OpCode    = instr_q[31:26];

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Scoreboard bench for fetch_mem_unit: driver issues ops and predicts results, a memory
// responder acks with planned latency, a monitor checks each transaction as Busy rises/falls.
`timescale 1ns/1ps
module tb_fetch_mem_unit;

   localparam int unsigned TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0, IorD = 1'b0, PCWrite = 1'b0;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] ALUResult = '0, ALUOut = '0, RegB = '0;
   logic [5:0]  OpCode;
   logic [31:0] Instr, MDR, PC;
   logic        Busy, Err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   fetch_mem_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .IorD      (IorD),
      .PCWrite   (PCWrite),
      .PCSrc     (PCSrc),
      .ALUResult (ALUResult),
      .ALUOut    (ALUOut),
      .RegB      (RegB),
      .OpCode    (OpCode),
      .Instr     (Instr),
      .MDR       (MDR),
      .PC        (PC),
      .Busy      (Busy),
      .Err       (Err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          busy;
      logic [31:0] mdr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
   } resp_t;

   exp_t  sb[$];
   resp_t rq[$];
   int    n_chk = 0;
   int    n_fail = 0;
   bit    ack_hi = 1'b0;

   // Reference model state
   logic [31:0] m_pc = '0, m_instr = '0, m_mdr = '0;
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] next_pc(input logic [1:0] src, input logic [31:0] ar,
                                           input logic [31:0] ao, input logic [31:0] pc,
                                           input logic [31:0] ins);
      case (src)
         2'b00:   return ar;
         2'b01:   return ao;
         2'b10:   return {pc[31:28], ins[25:0], 2'b00};
         default: return pc;
      endcase
   endfunction

   // Memory responder: acks after the planned number of wait cycles, random ack noise when idle
   int    r_cnt = 0;
   resp_t r_cur;
   always @(negedge clk) begin
      automatic resp_t r;
      if (!rst) begin
         r_cnt   <= 0;
         mem_ack <= 1'b0;
      end else if (mem_req) begin
         if (r_cnt == 0) begin
            if (rq.size() > 0) r = rq.pop_front();
            else r = '{1000, 32'd0};
            r_cur <= r;
         end else begin
            r = r_cur;
         end
         mem_ack   <= (r_cnt == r.lat);
         mem_rdata <= (r_cnt == r.lat) ? r.rdata : $urandom;
         r_cnt     <= r_cnt + 1;
      end else begin
         r_cnt     <= 0;
         mem_ack   <= ack_hi ? 1'b1 : 1'($urandom);
         mem_rdata <= $urandom;
      end
   end

   // Monitor
   bit   prev_busy = 1'b0;
   int   b_cnt = 0;
   exp_t e_mon;
   always @(negedge clk) begin
      if (!rst) begin
         prev_busy <= 1'b0;
         b_cnt     <= 0;
      end else begin
         if (Busy && !prev_busy) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_txn: got mem_addr 0x%08h expected no transaction", mem_addr);
            end else begin
               chk("req_addr", mem_addr, sb[0].addr);
               chk("req_we", 32'(mem_we), 32'(sb[0].we));
               chk("req_mem_req", 32'(mem_req), 32'd1);
               if (sb[0].we) chk("req_wdata", mem_wdata, sb[0].wdata);
            end
            b_cnt <= 1;
         end else if (Busy) begin
            if (sb.size() > 0) begin
               chk("hold_addr", mem_addr, sb[0].addr);
               if (sb[0].we) chk("hold_wdata", mem_wdata, sb[0].wdata);
            end
            b_cnt <= b_cnt + 1;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL orphan_done: got completion expected none");
            end else begin
               e_mon = sb.pop_front();
               chk("busy_cycles", 32'(b_cnt), 32'(e_mon.busy));
               chk("done_mdr", MDR, e_mon.mdr);
               chk("done_instr", Instr, e_mon.instr);
               chk("done_opcode", 32'(OpCode), 32'(e_mon.instr[31:26]));
               chk("done_pc", PC, e_mon.pc);
               chk("done_err", 32'(Err), 32'(e_mon.err));
               chk("done_req", 32'(mem_req), 32'd0);
            end
         end
         prev_busy <= Busy;
      end
   end

   task automatic deassert();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
   endtask

   task automatic junk();
      MemRead   = 1'($urandom);
      MemWrite  = 1'($urandom);
      IRWrite   = 1'($urandom);
      IorD      = 1'($urandom);
      PCWrite   = 1'($urandom);
      PCSrc     = 2'($urandom);
      ALUResult = $urandom;
      ALUOut    = $urandom;
      RegB      = $urandom;
   endtask

   task automatic do_op(input bit rd, input bit wr, input bit irw, input bit iord, input bit pcw,
                        input logic [1:0] src, input logic [31:0] ar, input logic [31:0] ao,
                        input logic [31:0] rb, input int lat, input logic [31:0] rdata);
      exp_t        e;
      int          g;
      logic [31:0] pc0, ins0;
      g = 0;
      @(negedge clk);
      while (Busy && g < 100) begin
         junk();
         @(negedge clk);
         g++;
      end
      if (Busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL busy_stuck: got Busy=1 expected 0 within 100 cycles");
      end
      MemRead = rd; MemWrite = wr; IRWrite = irw; IorD = iord; PCWrite = pcw;
      PCSrc = src; ALUResult = ar; ALUOut = ao; RegB = rb;
      pc0  = m_pc;
      ins0 = m_instr;
      e    = '{default: '0};
      if (rd && wr) begin
         m_err = 1'b1;
      end else if (rd || wr) begin
         e.addr  = wr ? ao : (iord ? ao : pc0);
         e.we    = wr;
         e.wdata = rb;
         rq.push_back('{lat, rdata});
         if (lat < int'(TIMEOUT)) begin
            e.busy = lat + 1;
            if (rd) begin
               m_mdr = rdata;
               if (irw) m_instr = rdata;
            end
         end else begin
            e.busy = int'(TIMEOUT);
            m_err  = 1'b1;
         end
      end
      if (pcw) m_pc = next_pc(src, ar, ao, pc0, ins0);
      if (rd ^ wr) begin
         e.mdr   = m_mdr;
         e.instr = m_instr;
         e.pc    = m_pc;
         e.err   = m_err;
         sb.push_back(e);
      end
      @(negedge clk);
      deassert();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_pc"}, PC, m_pc);
      chk({tag, "_err"}, 32'(Err), 32'(m_err));
   endtask

   task automatic model_reset();
      sb.delete();
      rq.delete();
      m_pc = '0; m_instr = '0; m_mdr = '0; m_err = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pc"}, PC, 32'd0);
      chk({tag, "_instr"}, Instr, 32'd0);
      chk({tag, "_mdr"}, MDR, 32'd0);
      chk({tag, "_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_addr"}, mem_addr, 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_err"}, 32'(Err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, r, lat;
      bit rd, wr;
      #2 rst = 1'b0;
      #2 check_zero("reset");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;

      // Fetch with same-cycle ack and PC+4
      do_op(1, 0, 1, 0, 1, 2'b00, 32'd4, 32'd0, 32'd0, 0, 32'h8C22_0004);
      // Data read with three wait cycles
      do_op(1, 0, 0, 1, 0, 2'b00, 32'd0, 32'h100, 32'd0, 3, 32'h1234_5678);
      // Store
      do_op(0, 1, 0, 0, 0, 2'b00, 32'd0, 32'h200, 32'hDEAD_BEEF, 2, 32'd0);
      // Timeout, then a normal read with Err sticky
      do_op(1, 0, 1, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 99, 32'hFFFF_FFFF);
      do_op(1, 0, 0, 1, 0, 2'b00, 32'd0, 32'h104, 32'd0, 1, 32'hCAFE_F00D);
      // Conflict, then jump
      do_op(1, 1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 0, 32'd0);
      check_idle("conflict");
      do_op(1, 0, 1, 0, 1, 2'b00, 32'h4000_0000, 32'd0, 32'd0, 0, 32'h0800_0010);
      do_op(0, 0, 0, 0, 1, 2'b10, 32'd0, 32'd0, 32'd0, 0, 32'd0);
      check_idle("jump");
      chk("jump_target", PC, 32'h4000_0040);

      // Reset in the middle of a read that never acks
      do_op(1, 0, 1, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 99, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero("midrst");
      model_reset();
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      ack_hi = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("late_ack");
      chk("late_ack_mdr", MDR, 32'd0);
      ack_hi = 1'b0;

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 99);
         rd = (k < 45) || (k >= 95);
         wr = ((k >= 45) && (k < 70)) || (k >= 95);
         r = $urandom_range(0, 19);
         if (r < 12) lat = r % 6;
         else if (r < 15) lat = int'(TIMEOUT) - 1;
         else if (r < 17) lat = 99;
         else lat = 0;
         do_op(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom,
               $urandom, $urandom, lat, $urandom);
         if (!(rd ^ wr)) check_idle("rand_idle");
      end

      @(negedge clk);
      for (int g = 0; g < 100 && Busy; g++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_idle("final");
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
